// File: rtl/register_file.sv
// rtl/register_file.sv - addressable register bank with arithmetic write port and two forwarding read ports
module register_file #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int ZERO_REG = 0,
  parameter int ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [1:0]        wop,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re_a,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [WIDTH-1:0]  rdata_a,
  output logic              rvalid_a,
  input  logic              re_b,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_b,
  output logic              rvalid_b
);

  localparam logic ZERO_EN = (ZERO_REG != 0);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [WIDTH-1:0] wr_val;
  logic             wr_en;
  logic [WIDTH-1:0] fwd_a;
  logic [WIDTH-1:0] fwd_b;

  always_comb begin
    wr_val = wdata;
    case (wop)
      2'b00:   wr_val = wdata;
      2'b01:   wr_val = regs[waddr] + WIDTH'(1);
      2'b10:   wr_val = regs[waddr] - WIDTH'(1);
      default: wr_val = '0;
    endcase
  end

  // Register 0 is hardwired to zero in ZERO_REG builds, so writes to it are dropped.
  assign wr_en = we && !(ZERO_EN && (waddr == '0));

  // Read ports see this edge's write result, not the stale register contents.
  assign fwd_a = (ZERO_EN && (raddr_a == '0))  ? '0     :
                 (wr_en && (waddr == raddr_a)) ? wr_val : regs[raddr_a];
  assign fwd_b = (ZERO_EN && (raddr_b == '0))  ? '0     :
                 (wr_en && (waddr == raddr_b)) ? wr_val : regs[raddr_b];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      rdata_a  <= '0;
      rdata_b  <= '0;
      rvalid_a <= 1'b0;
      rvalid_b <= 1'b0;
    end else begin
      if (wr_en) begin
        regs[waddr] <= wr_val;
      end
      rvalid_a <= re_a;
      rvalid_b <= re_b;
      if (re_a) begin
        rdata_a <= fwd_a;
      end
      if (re_b) begin
        rdata_b <= fwd_b;
      end
    end
  end

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - self-checking bench for register_file, plain and zero-register builds
module tb_register_file;
  localparam int W  = 16;
  localparam int D  = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          we = 1'b0;
  logic [1:0]    wop = 2'b00;
  logic [AW-1:0] waddr = '0;
  logic [W-1:0]  wdata = '0;
  logic          re_a = 1'b0;
  logic [AW-1:0] raddr_a = '0;
  logic          re_b = 1'b0;
  logic [AW-1:0] raddr_b = '0;

  logic [W-1:0] rdata_a0, rdata_b0, rdata_a1, rdata_b1;
  logic         rvalid_a0, rvalid_b0, rvalid_a1, rvalid_b1;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] m0 [D];
  logic [W-1:0] m1 [D];
  logic [W-1:0] ea0, eb0, ea1, eb1;
  logic         eva, evb;
  logic         soak_on = 1'b0;

  always #5 clk = ~clk;

  register_file #(.WIDTH(W), .DEPTH(D), .ZERO_REG(0)) dut0 (
    .clk(clk), .reset(reset), .we(we), .wop(wop), .waddr(waddr), .wdata(wdata),
    .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a0), .rvalid_a(rvalid_a0),
    .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b0), .rvalid_b(rvalid_b0)
  );

  register_file #(.WIDTH(W), .DEPTH(D), .ZERO_REG(1)) dut1 (
    .clk(clk), .reset(reset), .we(we), .wop(wop), .waddr(waddr), .wdata(wdata),
    .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a1), .rvalid_a(rvalid_a1),
    .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b1), .rvalid_b(rvalid_b1)
  );

  function automatic logic [W-1:0] op_result(input logic [W-1:0] old, input logic [1:0] op,
                                             input logic [W-1:0] wd);
    int unsigned v;
    case (op)
      2'd0:    v = wd;
      2'd1:    v = (int'(old) + 1) % 65536;
      2'd2:    v = (int'(old) + 65535) % 65536;
      default: v = 0;
    endcase
    return v[W-1:0];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < D; i++) begin
      m0[i] = '0;
      m1[i] = '0;
    end
    ea0 = '0; eb0 = '0; ea1 = '0; eb1 = '0;
    eva = 1'b0; evb = 1'b0;
  endtask

  // Applies one clock edge's worth of behaviour to the reference model.
  task automatic model_edge(input logic [W-1:0] wd);
    if (we) begin
      m0[waddr] = op_result(m0[waddr], wop, wd);
      if (waddr != 0) m1[waddr] = op_result(m1[waddr], wop, wd);
    end
    eva = re_a;
    evb = re_b;
    if (re_a) begin ea0 = m0[raddr_a]; ea1 = m1[raddr_a]; end
    if (re_b) begin eb0 = m0[raddr_b]; eb1 = m1[raddr_b]; end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(wdata);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; re_a = 1'b0; re_b = 1'b0;
  endtask

  task automatic wr_rd(input logic [1:0] op, input logic [AW-1:0] a, input logic [W-1:0] d);
    we = 1'b1; wop = op; waddr = a; wdata = d;
    re_a = 1'b1; raddr_a = a; re_b = 1'b1; raddr_b = a;
    tick();
    idle();
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    checks++; if (rdata_a0 !== 16'h0 || rdata_b0 !== 16'h0) begin errors++;
      $display("FAIL reset_init_data a=%h b=%h exp 0000", rdata_a0, rdata_b0); end
    checks++; if (rvalid_a0 !== 1'b0 || rvalid_b1 !== 1'b0) begin errors++;
      $display("FAIL reset_init_valid a=%b b=%b exp 0", rvalid_a0, rvalid_b1); end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    wr_rd(2'd0, 3'd3, 16'hBEEF);
    checks++; if (rdata_a0 !== 16'hBEEF || rdata_b0 !== 16'hBEEF) begin errors++;
      $display("FAIL pre_reset_r3 a=%h b=%h exp beef", rdata_a0, rdata_b0); end
    #3 reset = 1'b1;
    #1;
    checks++; if (rdata_a0 !== 16'h0 || rdata_b0 !== 16'h0 || rdata_a1 !== 16'h0) begin errors++;
      $display("FAIL async_reset_data a=%h b=%h exp 0000", rdata_a0, rdata_b0); end
    checks++; if (rvalid_a0 !== 1'b0 || rvalid_b0 !== 1'b0) begin errors++;
      $display("FAIL async_reset_valid a=%b b=%b exp 0", rvalid_a0, rvalid_b0); end
    #1 reset = 1'b0;
    model_reset();
    re_a = 1'b1; raddr_a = 3'd3;
    tick();
    idle();
    checks++; if (rdata_a0 !== 16'h0 || rvalid_a0 !== 1'b1) begin errors++;
      $display("FAIL r3_after_reset data=%h valid=%b exp 0000/1", rdata_a0, rvalid_a0); end
  endtask

  task automatic test_load_dual_read();
    we = 1'b1; wop = 2'd0; waddr = 3'd1; wdata = 16'h1234; tick();
    waddr = 3'd2; wdata = 16'hABCD; tick();
    idle();
    re_a = 1'b1; raddr_a = 3'd1; re_b = 1'b1; raddr_b = 3'd2;
    tick();
    idle();
    checks++; if (rdata_a0 !== 16'h1234 || rdata_b0 !== 16'hABCD) begin errors++;
      $display("FAIL dual_read a=%h b=%h exp 1234/abcd", rdata_a0, rdata_b0); end
    checks++; if (rvalid_a0 !== 1'b1 || rvalid_b0 !== 1'b1) begin errors++;
      $display("FAIL dual_read_valid a=%b b=%b exp 1/1", rvalid_a0, rvalid_b0); end
    tick();
    checks++; if (rvalid_a0 !== 1'b0 || rvalid_b0 !== 1'b0) begin errors++;
      $display("FAIL idle_valid a=%b b=%b exp 0/0", rvalid_a0, rvalid_b0); end
    checks++; if (rdata_a0 !== 16'h1234 || rdata_b0 !== 16'hABCD) begin errors++;
      $display("FAIL idle_hold a=%h b=%h exp 1234/abcd", rdata_a0, rdata_b0); end
  endtask

  task automatic test_arith_wrap();
    wr_rd(2'd0, 3'd5, 16'hFFFF);
    checks++; if (rdata_a0 !== 16'hFFFF) begin errors++;
      $display("FAIL wrap_load got=%h exp ffff", rdata_a0); end
    wr_rd(2'd1, 3'd5, 16'h0);
    checks++; if (rdata_a0 !== 16'h0000) begin errors++;
      $display("FAIL wrap_inc got=%h exp 0000", rdata_a0); end
    wr_rd(2'd2, 3'd5, 16'h0);
    checks++; if (rdata_b0 !== 16'hFFFF) begin errors++;
      $display("FAIL wrap_dec1 got=%h exp ffff", rdata_b0); end
    wr_rd(2'd2, 3'd5, 16'h0);
    checks++; if (rdata_a0 !== 16'hFFFE) begin errors++;
      $display("FAIL wrap_dec2 got=%h exp fffe", rdata_a0); end
    wr_rd(2'd3, 3'd5, 16'h1111);
    checks++; if (rdata_a0 !== 16'h0000) begin errors++;
      $display("FAIL clear got=%h exp 0000", rdata_a0); end
  endtask

  task automatic test_forward();
    we = 1'b1; wop = 2'd0; waddr = 3'd4; wdata = 16'h5A5A; re_a = 1'b1; raddr_a = 3'd4;
    tick();
    checks++; if (rdata_a0 !== 16'h5A5A) begin errors++;
      $display("FAIL fwd_load got=%h exp 5a5a", rdata_a0); end
    wop = 2'd1; wdata = 16'h0000;
    tick();
    idle();
    checks++; if (rdata_a0 !== 16'h5A5B) begin errors++;
      $display("FAIL fwd_inc got=%h exp 5a5b", rdata_a0); end
  endtask

  task automatic test_zero_reg();
    wr_rd(2'd0, 3'd0, 16'h7777);
    checks++; if (rdata_a1 !== 16'h0 || rdata_b1 !== 16'h0) begin errors++;
      $display("FAIL zero_fwd a=%h b=%h exp 0000", rdata_a1, rdata_b1); end
    checks++; if (rdata_a0 !== 16'h7777) begin errors++;
      $display("FAIL plain_r0 got=%h exp 7777", rdata_a0); end
    re_a = 1'b1; raddr_a = 3'd0; re_b = 1'b1; raddr_b = 3'd1;
    tick();
    idle();
    checks++; if (rdata_a1 !== 16'h0 || rdata_b1 !== 16'h1234) begin errors++;
      $display("FAIL zero_read a=%h b=%h exp 0000/1234", rdata_a1, rdata_b1); end
    wr_rd(2'd1, 3'd0, 16'h0);
    checks++; if (rdata_a1 !== 16'h0 || rdata_a0 !== 16'h7778) begin errors++;
      $display("FAIL zero_inc z=%h p=%h exp 0000/7778", rdata_a1, rdata_a0); end
  endtask

  task automatic test_random_soak();
    logic [W-1:0] wd_x, wd_y;
    logic         tog;
    wd_x = W'($urandom); wd_y = W'($urandom); tog = 1'b0;
    soak_on = 1'b1;
    fork
      while (soak_on) begin
        #2;
        wdata = tog ? wd_x : wd_y;
        tog = ~tog;
      end
    join_none
    for (int n = 0; n < 10000; n++) begin
      we = 1'($urandom); wop = 2'($urandom); waddr = AW'($urandom_range(0, D - 1));
      re_a = 1'($urandom); raddr_a = AW'($urandom_range(0, D - 1));
      re_b = 1'($urandom); raddr_b = AW'($urandom_range(0, D - 1));
      wd_x = W'($urandom); wd_y = W'($urandom);
      tick();
      checks++; if (rdata_a0 !== ea0 || rvalid_a0 !== eva) begin errors++;
        $display("FAIL soak_a0 n=%0d got=%h/%b exp %h/%b", n, rdata_a0, rvalid_a0, ea0, eva); end
      checks++; if (rdata_b0 !== eb0 || rvalid_b0 !== evb) begin errors++;
        $display("FAIL soak_b0 n=%0d got=%h/%b exp %h/%b", n, rdata_b0, rvalid_b0, eb0, evb); end
      checks++; if (rdata_a1 !== ea1 || rvalid_a1 !== eva) begin errors++;
        $display("FAIL soak_a1 n=%0d got=%h/%b exp %h/%b", n, rdata_a1, rvalid_a1, ea1, eva); end
      checks++; if (rdata_b1 !== eb1 || rvalid_b1 !== evb) begin errors++;
        $display("FAIL soak_b1 n=%0d got=%h/%b exp %h/%b", n, rdata_b1, rvalid_b1, eb1, evb); end
    end
    soak_on = 1'b0;
    #4;
    idle();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load_dual_read();
    test_arith_wrap();
    test_forward();
    test_zero_reg();
    test_random_soak();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_file.md
# register_file

Parametrised multi-register storage block for the 16-bit datapath, generalising the single 1-bit and 16-bit load registers into an addressable bank. It has one write port with a small operation set (load, increment, decrement, clear) and two independent registered read ports with write-to-read forwarding. It sits between the control unit and the ALU and serves as the general-purpose register bank of the CPU.

## Interface
Parameters:
- WIDTH, 16, data width of each register in bits (≥1).
- DEPTH, 8, number of registers; power of two, ≥2.
- ZERO_REG, 0, when 1 register 0 always reads 0 and ignores all writes.
- ADDR_W, $clog2(DEPTH), derived address width; not to be overridden.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- we  input  1  write enable; performs wop on register waddr this edge.
- wop  input  2  write operation: 00 load wdata, 01 increment, 10 decrement, 11 clear.
- waddr  input  ADDR_W  write target register.
- wdata  input  WIDTH  load value; ignored unless wop=00.
- re_a  input  1  read enable, port A.
- raddr_a  input  ADDR_W  read address, port A.
- rdata_a  output  WIDTH  registered read data, port A.
- rvalid_a  output  1  high for one cycle when rdata_a was updated by a read.
- re_b, raddr_b, rdata_b, rvalid_b: identical to port A, independent.

## Operation
- Storage: DEPTH × WIDTH flip-flop registers.
- Reset (asynchronous, any time): every register, rdata_a, rdata_b → 0; rvalid_a, rvalid_b → 0. Takes effect immediately, without waiting for clk. A write or read in flight at assertion is discarded. The first operation is accepted on the first rising edge after reset is deasserted.
- Write, on an edge with we=1:
  - 00: reg[waddr] ← wdata.
  - 01: reg[waddr] ← reg[waddr]+1, modulo 2^WIDTH (all-ones wraps to 0).
  - 10: reg[waddr] ← reg[waddr]−1, modulo 2^WIDTH (0 wraps to all-ones).
  - 11: reg[waddr] ← 0.
  - No carry or borrow output; arithmetic is unsigned WIDTH bits.
- ZERO_REG=1: a write to address 0 has no effect. Reads of address 0 return 0, including when forwarded.
- Read, on an edge with re_x=1: rdata_x ← value of reg[raddr_x] after this edge's write is applied, and rvalid_x ← 1.
  - Forwarding: if we=1 and waddr=raddr_x on the same edge, rdata_x gets the post-operation value (new wdata, incremented, decremented or 0), never the stale value.
- Read, on an edge with re_x=0: rdata_x holds its previous value and rvalid_x ← 0.
- Ports A and B may read the same address on the same edge; both get identical data.
- Out-of-range addresses cannot occur, because DEPTH is a power of two.

## Timing
- Write latency: the register updates on the edge where we=1. It is visible to a read issued on the same edge through forwarding.
- Read latency: 1 cycle. Address presented before edge N gives rdata/rvalid valid after edge N, held until the next enabled read or reset.
- Throughput: one write and two reads every cycle, with no stalls or backpressure.
- rvalid_x is a single-cycle pulse per enabled read. Back-to-back reads keep it high continuously.
- All inputs are sampled only on rising clk. Outputs change only on rising clk or on reset assertion.

## Test plan
- Reset/defaults: assert reset mid-cycle after writing 16'hBEEF to r3 → rdata_a/b=0 and rvalid=0 immediately, without a clock edge. Read r3 after release → 16'h0000.
- Load and dual read: load r1=16'h1234 and r2=16'hABCD, then re_a on r1 and re_b on r2 in the same cycle → next cycle rdata_a=16'h1234, rdata_b=16'hABCD, both rvalid=1. Following idle cycle → rvalid=0, data held.
- Arithmetic wrap: load r5=16'hFFFF, then increment → 16'h0000. Decrement twice → 16'hFFFE. Clear → 16'h0000.
- Forwarding: same edge, we=1 wop=00 waddr=4 wdata=16'h5A5A, with re_a raddr_a=4 → rdata_a=16'h5A5A next cycle. Repeat with wop=01 on r4 → rdata_a=16'h5A5B.
- ZERO_REG=1 build: load r0=16'h7777, then read r0 on both ports (including a same-edge forwarded read) → 16'h0000. Other registers unaffected.
- Random soak: 10,000 cycles of random we/wop/addresses/re against a reference model. Also alternate the write data every 2 ns against the 10 ns clock (5 ns half-period) and check that only values present at rising edges are captured.
